// File: rtl/spp_pkg.sv
// Shared types for the SPP job dispatcher: FSM state encoding, default datapath
// width and the packed operand-pair layout.
package spp_pkg;

    localparam int SPP_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        HOLD   = 2'd3
    } spp_state_t;

    typedef struct packed {
        logic [SPP_DATA_W-1:0] a;
        logic [SPP_DATA_W-1:0] b;
    } spp_pair_t;

endpackage

// File: rtl/spp_operand_fifo.sv
// Operand-pair FIFO: DEPTH entries, natural-wrap pointers, full/empty from an
// occupancy counter one bit wider than the pointers.
module spp_operand_fifo
    import spp_pkg::*;
#(
    parameter int WIDTH = 2 * SPP_DATA_W,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_wr;
    logic             w_rd;

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    // A pop in the same cycle does not make room: full always blocks the push.
    assign w_wr    = i_push && !o_full;
    assign w_rd    = i_pop && !o_empty;
    assign o_rdata = r_mem[r_rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage has no reset; the pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule

// File: rtl/spp_job_dispatcher.sv
// Feeds buffered (A,B) pairs to the SPP core over Start/Busy and returns Out on a
// valid/ready result stream. Optional busy watchdog: define SPP_DISP_TIMEOUT_EN.
module spp_job_dispatcher
    import spp_pkg::*;
#(
    parameter int DATA_W = SPP_DATA_W,
    parameter int DEPTH  = 4
`ifdef SPP_DISP_TIMEOUT_EN
    ,
    parameter int BUSY_TIMEOUT = 255
`endif
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              spp_start,
    input  logic              spp_busy,
    output logic [DATA_W-1:0] spp_ina,
    output logic [DATA_W-1:0] spp_inb,
    input  logic [DATA_W-1:0] spp_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_err
);

    spp_state_t          r_state;
    spp_state_t          w_next_state;
    logic                r_ready_en;
    logic [DATA_W-1:0]   r_ina;
    logic [DATA_W-1:0]   r_inb;
    logic [DATA_W-1:0]   r_res_data;
    logic [2*DATA_W-1:0] w_head;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic                w_capture;
    logic                w_timeout;
    logic                w_tmo_hit;

    // in_ready is held low through reset and rises on the first edge after release.
    assign in_ready = r_ready_en && !w_full;
    assign w_push   = in_valid && in_ready;

    spp_operand_fifo #(
        .WIDTH (2 * DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_wdata ({in_a, in_b}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_capture    = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = LAUNCH;
                end
            end
            LAUNCH: begin
                if (spp_busy) begin
                    w_next_state = WAIT;
                end else if (w_tmo_hit) begin
                    w_timeout    = 1'b1;
                    w_next_state = HOLD;
                end
            end
            WAIT: begin
                if (!spp_busy) begin
                    w_capture    = 1'b1;
                    w_next_state = HOLD;
                end else if (w_tmo_hit) begin
                    w_timeout    = 1'b1;
                    w_next_state = HOLD;
                end
            end
            HOLD: begin
                if (res_ready) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_ready_en <= 1'b0;
            r_ina      <= '0;
            r_inb      <= '0;
            r_res_data <= '0;
        end else begin
            r_state    <= w_next_state;
            r_ready_en <= 1'b1;
            if (w_pop) {r_ina, r_inb} <= w_head;
            if (w_capture)      r_res_data <= spp_out;
            else if (w_timeout) r_res_data <= '0;
        end
    end

    assign spp_start = (r_state == LAUNCH);
    assign res_valid = (r_state == HOLD);
    assign spp_ina   = r_ina;
    assign spp_inb   = r_inb;
    assign res_data  = r_res_data;

`ifdef SPP_DISP_TIMEOUT_EN
    localparam int TMO_W = $clog2(BUSY_TIMEOUT + 1);

    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_res_err;

    // The counter restarts on every state change, so LAUNCH and WAIT each get the full budget.
    assign w_tmo_hit = (r_tmo_cnt == TMO_W'(BUSY_TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tmo_cnt <= '0;
            r_res_err <= 1'b0;
        end else begin
            if ((w_next_state != r_state) || ((r_state != LAUNCH) && (r_state != WAIT)))
                r_tmo_cnt <= '0;
            else
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            if (w_timeout)                          r_res_err <= 1'b1;
            else if (w_capture)                     r_res_err <= 1'b0;
            else if ((r_state == HOLD) && res_ready) r_res_err <= 1'b0;
        end
    end

    assign res_err = r_res_err;
`else
    assign w_tmo_hit = 1'b0;
    assign res_err   = 1'b0;
`endif

endmodule

// File: tb/tb_spp_job_dispatcher.sv
// Directed bench for spp_job_dispatcher with a behavioural core: Busy one cycle
// after Start, held three cycles, Out = A + B.
module tb_spp_job_dispatcher;
    import spp_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_a = '0;
    logic [7:0] in_b = '0;
    logic       spp_start;
    logic       core_busy;
    logic [7:0] spp_ina;
    logic [7:0] spp_inb;
    logic [7:0] core_out;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [7:0] res_data;
    logic       res_err;

    logic       hold_busy = 1'b0;
    logic       never_busy = 1'b0;
    int         core_cnt;

    int n_vec = 0;
    int n_err = 0;

    int   cyc = 0;
    int   n_start = 0;
    int   n_vrise = 0;
    int   start_rise_cyc = 0;
    int   busy_fall_cyc = 0;
    int   valid_rise_cyc = 0;
    logic prev_start = 1'b0;
    logic prev_busy = 1'b0;
    logic prev_valid = 1'b0;

    always #5 clk = ~clk;

    spp_job_dispatcher #(
        .DATA_W (8),
        .DEPTH  (4)
`ifdef SPP_DISP_TIMEOUT_EN
        ,
        .BUSY_TIMEOUT (8)
`endif
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .spp_start (spp_start),
        .spp_busy  (core_busy),
        .spp_ina   (spp_ina),
        .spp_inb   (spp_inb),
        .spp_out   (core_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_err   (res_err)
    );

    // Core model shares reset_n with the dispatcher.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            core_busy <= 1'b0;
            core_cnt  <= 0;
            core_out  <= '0;
        end else if (core_busy) begin
            if (hold_busy)         core_cnt  <= core_cnt;
            else if (core_cnt > 1) core_cnt  <= core_cnt - 1;
            else                   core_busy <= 1'b0;
        end else if (spp_start && !never_busy) begin
            core_busy <= 1'b1;
            core_cnt  <= 3;
            core_out  <= spp_ina + spp_inb;
        end
    end

    // Edge monitor: sees pre-edge values, so each event is stamped one cycle after it became visible.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (spp_start && !prev_start) begin
            n_start        = n_start + 1;
            start_rise_cyc = cyc;
        end
        if (prev_busy && !core_busy) busy_fall_cyc = cyc;
        if (res_valid && !prev_valid) begin
            n_vrise        = n_vrise + 1;
            valid_rise_cyc = cyc;
        end
        prev_start = spp_start;
        prev_busy  = core_busy;
        prev_valid = res_valid;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "bench watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec = n_vec + 1;
        assert (obs === exp) else begin
            n_err = n_err + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [7:0] a, input logic [7:0] b);
        int w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int w = 0;
        while (!res_valid && w < 100) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_valid"}, 32'(res_valid), 32'd1);
    endtask

    // Caller holds res_ready=1; returns one negedge past the handshake edge.
    task automatic get_result(input string tag, input logic [7:0] exp);
        wait_valid(tag);
        check(tag, 32'(res_data), 32'(exp));
        @(negedge clk);
    endtask

    spp_pair_t fill [5];
    logic [7:0] fill_sum [5];
    int s0;
    int v0;
    int w;

    initial begin
        fill[0] = '{a: 8'h01, b: 8'h02}; fill_sum[0] = 8'h03;
        fill[1] = '{a: 8'h10, b: 8'h20}; fill_sum[1] = 8'h30;
        fill[2] = '{a: 8'h33, b: 8'h44}; fill_sum[2] = 8'h77;
        fill[3] = '{a: 8'h80, b: 8'h7F}; fill_sum[3] = 8'hFF;
        fill[4] = '{a: 8'hFF, b: 8'h02}; fill_sum[4] = 8'h01;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_spp_start", 32'(spp_start), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_data",  32'(res_data),  32'd0);
        check("rst_spp_ina",   32'(spp_ina),   32'd0);
        check("rst_res_err",   32'(res_err),   32'd0);
        reset_n = 1'b1;
        #1 check("rel_in_ready_low", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("rel_in_ready_high", 32'(in_ready), 32'd1);

        // 1: single job
        res_ready = 1'b1;
        s0 = n_start;
        push("t1_push", 8'hF0, 8'h0F);
        w = 0;
        while (!spp_start && w < 10) begin
            @(negedge clk);
            w++;
        end
        check("t1_start", 32'(spp_start), 32'd1);
        check("t1_ina",   32'(spp_ina),   32'hF0);
        check("t1_inb",   32'(spp_inb),   32'h0F);
        get_result("t1_res", 8'hFF);
        check("t1_ina_stable",  32'(spp_ina), 32'hF0);
        check("t1_inb_stable",  32'(spp_inb), 32'h0F);
        check("t1_one_start",   32'(n_start - s0), 32'd1);
        check("t1_valid_lat",   32'(valid_rise_cyc - busy_fall_cyc), 32'd1);
        check("t1_valid_drop",  32'(res_valid), 32'd0);

        // 2: fill with core held busy; four entries resident after the fifth accept
        hold_busy = 1'b1;
        s0 = n_start;
        for (int i = 0; i < 5; i++) begin
            push("t2_push", fill[i].a, fill[i].b);
            if (i == 3) check("t2_ready_after4", 32'(in_ready), 32'd1);
        end
        check("t2_full", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_a     = 8'hEE;
        in_b     = 8'hEE;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t2_full_hold", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        hold_busy = 1'b0;
        for (int i = 0; i < 5; i++) get_result("t2_res", fill_sum[i]);
        check("t2_starts",    32'(n_start - s0), 32'd5);
        check("t2_ready_end", 32'(in_ready), 32'd1);

        // 3: output backpressure
        res_ready = 1'b0;
        push("t3_push", 8'h11, 8'h22);
        push("t3_push", 8'h40, 8'h05);
        wait_valid("t3_a");
        check("t3_a_data", 32'(res_data), 32'h33);
        s0 = n_start;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t3_hold_valid", 32'(res_valid), 32'd1);
            check("t3_hold_data",  32'(res_data),  32'h33);
        end
        check("t3_no_start", 32'(n_start - s0), 32'd0);
        res_ready = 1'b1;
        @(negedge clk);
        check("t3_gap_start", 32'(spp_start), 32'd0);
        check("t3_gap_valid", 32'(res_valid), 32'd0);
        @(negedge clk);
        check("t3_next_start", 32'(spp_start), 32'd1);
        check("t3_next_ina",   32'(spp_ina),   32'h40);
        check("t3_next_inb",   32'(spp_inb),   32'h05);
        get_result("t3_b", 8'h45);

        // 4: push and pop in the same cycle with one entry queued
        res_ready = 1'b0;
        push("t4_push", 8'h05, 8'h06);
        push("t4_push", 8'h07, 8'h08);
        wait_valid("t4_x");
        check("t4_x_data", 32'(res_data), 32'h0B);
        check("t4_count_before", 32'(dut.u_fifo.r_count), 32'd1);
        s0 = n_start;
        res_ready = 1'b1;
        @(negedge clk);
        check("t4_z_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_a     = 8'h09;
        in_b     = 8'h0A;
        @(negedge clk);
        in_valid = 1'b0;
        check("t4_count_same", 32'(dut.u_fifo.r_count), 32'd1);
        check("t4_start",      32'(spp_start), 32'd1);
        check("t4_ina",        32'(spp_ina),   32'h07);
        check("t4_inb",        32'(spp_inb),   32'h08);
        get_result("t4_y", 8'h0F);
        get_result("t4_z", 8'h13);
        repeat (20) @(negedge clk);
        check("t4_starts",      32'(n_start - s0), 32'd2);
        check("t4_idle_valid",  32'(res_valid), 32'd0);
        check("t4_count_empty", 32'(dut.u_fifo.r_count), 32'd0);

        // 5: reset in the middle of WAIT
        push("t5_push", 8'h21, 8'h12);
        push("t5_push", 8'h01, 8'h01);
        w = 0;
        while (!core_busy && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("t5_busy", 32'(core_busy), 32'd1);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("t5_rst_start",    32'(spp_start), 32'd0);
        check("t5_rst_valid",    32'(res_valid), 32'd0);
        check("t5_rst_in_ready", 32'(in_ready),  32'd0);
        check("t5_rst_ina",      32'(spp_ina),   32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        s0 = n_start;
        v0 = n_vrise;
        repeat (20) @(negedge clk);
        check("t5_no_start",  32'(n_start - s0), 32'd0);
        check("t5_no_result", 32'(n_vrise - v0), 32'd0);
        check("t5_in_ready",  32'(in_ready), 32'd1);
        check("t5_empty",     32'(dut.u_fifo.r_count), 32'd0);
        push("t5_push", 8'h03, 8'h04);
        get_result("t5_res", 8'h07);

`ifdef SPP_DISP_TIMEOUT_EN
        // 6: watchdog with a core that never raises Busy
        never_busy = 1'b1;
        res_ready  = 1'b0;
        push("t6_push", 8'hAA, 8'h55);
        wait_valid("t6_tmo");
        check("t6_err",   32'(res_err),   32'd1);
        check("t6_data",  32'(res_data),  32'd0);
        check("t6_start", 32'(spp_start), 32'd0);
        res_ready = 1'b1;
        @(negedge clk);
        check("t6_tmo_len", 32'(valid_rise_cyc - start_rise_cyc), 32'd8);
        never_busy = 1'b0;
        push("t6_push", 8'h01, 8'h02);
        wait_valid("t6_next");
        check("t6_next_err",  32'(res_err),  32'd0);
        check("t6_next_data", 32'(res_data), 32'h03);
        @(negedge clk);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
